// File: rtl/maq_bcd_mod_pkg.sv
// Shared types and constants for the clock's BCD field counters.
package maq_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int MOD_SEG  = 60;
    localparam int MOD_MIN  = 60;
    localparam int MOD_HORA = 24;

    // Binary 0..99 to packed {tens, units}; used for elaboration-time constants.
    function automatic logic [7:0] bcd_split(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/maq_bcd_mod_if.sv
// Control and digit bus of one BCD modulo counter stage.
interface maq_bcd_mod_if #(
    parameter int MSD_W = 3
);
    import maq_pkg::*;

    logic             en;
    logic             up;
    logic             load;
    bcd_digit_t       load_lsd;
    logic [MSD_W-1:0] load_msd;
    bcd_digit_t       bcd_lsd;
    logic [MSD_W-1:0] bcd_msd;
    logic             carry_out;
    logic             load_err;

    modport master (
        output en, up, load, load_lsd, load_msd,
        input  bcd_lsd, bcd_msd, carry_out, load_err
    );

    modport slave (
        input  en, up, load, load_lsd, load_msd,
        output bcd_lsd, bcd_msd, carry_out, load_err
    );

endinterface

// File: rtl/maq_bcd_mod_digito.sv
// One decade counter 0..max_val with load; the parent handles cross-digit wrap.
module maq_digito_bcd #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] digit,
    output logic         at_max,
    output logic         at_zero
);

    assign at_max  = (digit == max_val);
    assign at_zero = (digit == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= RST_VAL;
        end else if (load) begin
            digit <= load_val;
        end else if (en) begin
            if (up) begin
                digit <= at_max ? '0 : digit + W'(1);
            end else begin
                digit <= at_zero ? max_val : digit - W'(1);
            end
        end
    end

endmodule

// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo counter with enable, direction, checked load and a
// combinational carry/borrow for zero-latency cascading.
module maq_bcd_mod
    import maq_pkg::*;
#(
    parameter int MODULO    = 60,
    parameter int MSD_W     = 3,
    parameter int RESET_VAL = 0
) (
    input logic          clk,
    input logic          rst,
    maq_bcd_mod_if.slave bus
);

    if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
        $error("maq_bcd_mod: MODULO must be in 2..100");
    end
    if ((MODULO - 1) / 10 >= (1 << MSD_W)) begin : g_bad_msd_w
        $error("maq_bcd_mod: MSD_W too narrow for MODULO-1 tens digit");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULO) begin : g_bad_reset
        $error("maq_bcd_mod: RESET_VAL must be below MODULO");
    end

    localparam logic [7:0]       MAX_BCD = bcd_split(MODULO - 1);
    localparam logic [7:0]       RST_BCD = bcd_split(RESET_VAL);
    localparam bcd_digit_t       MAX_LSD = MAX_BCD[3:0];
    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'(MAX_BCD[7:4]);

    bcd_digit_t       lsd;
    logic [MSD_W-1:0] msd;
    logic             lsd_at_max, lsd_at_zero, msd_at_max, msd_at_zero;
    logic [31:0]      load_sum;
    logic             legal, load_ok, cnt_en, at_top, at_bot, wrap;
    logic             lsd_ld, msd_en;
    bcd_digit_t       lsd_ld_val;
    logic [MSD_W-1:0] msd_ld_val;

    assign load_sum = 32'(bus.load_msd) * 32'd10 + 32'(bus.load_lsd);
    assign legal    = (bus.load_lsd <= 4'd9) && (load_sum < 32'(MODULO));
    assign load_ok  = bus.load & legal;

    // A rejected load still blocks counting: load outranks en regardless.
    assign cnt_en = bus.en & ~bus.load;
    assign at_top = (lsd == MAX_LSD) & msd_at_max;
    assign at_bot = lsd_at_zero & msd_at_zero;
    assign wrap   = cnt_en & (bus.up ? at_top : at_bot);

    // Modulo wrap reuses the digits' load path to jump to 00 or MODULO-1.
    assign lsd_ld     = load_ok | wrap;
    assign lsd_ld_val = load_ok ? bus.load_lsd : (bus.up ? '0 : MAX_LSD);
    assign msd_ld_val = load_ok ? bus.load_msd : (bus.up ? '0 : MAX_MSD);
    assign msd_en     = cnt_en & (bus.up ? lsd_at_max : lsd_at_zero);

    maq_digito_bcd #(
        .W       (4),
        .RST_VAL (RST_BCD[3:0])
    ) u_lsd (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .up       (bus.up),
        .load     (lsd_ld),
        .load_val (lsd_ld_val),
        .max_val  (4'd9),
        .digit    (lsd),
        .at_max   (lsd_at_max),
        .at_zero  (lsd_at_zero)
    );

    maq_digito_bcd #(
        .W       (MSD_W),
        .RST_VAL (MSD_W'(RST_BCD[7:4]))
    ) u_msd (
        .clk      (clk),
        .rst      (rst),
        .en       (msd_en),
        .up       (bus.up),
        .load     (lsd_ld),
        .load_val (msd_ld_val),
        .max_val  (MAX_MSD),
        .digit    (msd),
        .at_max   (msd_at_max),
        .at_zero  (msd_at_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.load_err <= 1'b0;
        end else begin
            bus.load_err <= bus.load & ~legal;
        end
    end

    assign bus.bcd_lsd   = lsd;
    assign bus.bcd_msd   = msd;
    assign bus.carry_out = wrap;

endmodule

// File: tb/tb_maq_bcd_mod.sv
// Scoreboard bench: stimulus queues expected digits/flags, a monitor compares.
module tb_maq_bcd_mod;
    import maq_pkg::*;

    typedef struct {
        int         id;
        int         at_cyc;
        bit         ph;
        logic [9:0] val;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_x;
    logic rst5;
    logic probe = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rst5 = rst | rst_x;

    maq_bcd_mod_if #(.MSD_W(3)) if60 ();
    maq_bcd_mod_if #(.MSD_W(3)) if24 ();
    maq_bcd_mod_if #(.MSD_W(3)) ifs ();
    maq_bcd_mod_if #(.MSD_W(3)) ifm ();
    maq_bcd_mod_if #(.MSD_W(3)) ifh ();
    maq_bcd_mod_if #(.MSD_W(3)) if5 ();
    maq_bcd_mod_if #(.MSD_W(4)) if100 ();
    maq_bcd_mod_if #(.MSD_W(3)) if10 ();

    assign ifm.en = ifs.carry_out;
    assign ifh.en = ifm.carry_out;

    maq_bcd_mod #(.MODULO(MOD_SEG), .MSD_W(3), .RESET_VAL(0))
        u60 (.clk(clk), .rst(rst), .bus(if60));
    maq_bcd_mod #(.MODULO(MOD_HORA), .MSD_W(3), .RESET_VAL(0))
        u24 (.clk(clk), .rst(rst), .bus(if24));
    maq_bcd_mod #(.MODULO(MOD_SEG), .MSD_W(3), .RESET_VAL(0))
        u_sec (.clk(clk), .rst(rst), .bus(ifs));
    maq_bcd_mod #(.MODULO(MOD_MIN), .MSD_W(3), .RESET_VAL(0))
        u_min (.clk(clk), .rst(rst), .bus(ifm));
    maq_bcd_mod #(.MODULO(MOD_HORA), .MSD_W(3), .RESET_VAL(0))
        u_hora (.clk(clk), .rst(rst), .bus(ifh));
    maq_bcd_mod #(.MODULO(60), .MSD_W(3), .RESET_VAL(5))
        u5 (.clk(clk), .rst(rst5), .bus(if5));
    maq_bcd_mod #(.MODULO(100), .MSD_W(4), .RESET_VAL(0))
        u100 (.clk(clk), .rst(rst), .bus(if100));
    maq_bcd_mod #(.MODULO(10), .MSD_W(3), .RESET_VAL(0))
        u10 (.clk(clk), .rst(rst), .bus(if10));

    // Packed observation: {load_err, carry_out, msd[3:0], lsd[3:0]}.
    function automatic logic [9:0] obs(input int id);
        case (id)
            0: obs = {if60.load_err, if60.carry_out, 1'b0, if60.bcd_msd, if60.bcd_lsd};
            1: obs = {if24.load_err, if24.carry_out, 1'b0, if24.bcd_msd, if24.bcd_lsd};
            2: obs = {ifs.load_err, ifs.carry_out, 1'b0, ifs.bcd_msd, ifs.bcd_lsd};
            3: obs = {ifm.load_err, ifm.carry_out, 1'b0, ifm.bcd_msd, ifm.bcd_lsd};
            4: obs = {ifh.load_err, ifh.carry_out, 1'b0, ifh.bcd_msd, ifh.bcd_lsd};
            5: obs = {if5.load_err, if5.carry_out, 1'b0, if5.bcd_msd, if5.bcd_lsd};
            6: obs = {if100.load_err, if100.carry_out, if100.bcd_msd, if100.bcd_lsd};
            7: obs = {if10.load_err, if10.carry_out, 1'b0, if10.bcd_msd, if10.bcd_lsd};
            default: obs = '0;
        endcase
    endfunction

    task automatic set_in(input int id, input bit en, input bit up, input bit ld,
                          input int lsd, input int msd);
        case (id)
            0: begin if60.en = en; if60.up = up; if60.load = ld;
                     if60.load_lsd = 4'(lsd); if60.load_msd = 3'(msd); end
            1: begin if24.en = en; if24.up = up; if24.load = ld;
                     if24.load_lsd = 4'(lsd); if24.load_msd = 3'(msd); end
            2: begin ifs.en = en; ifs.up = up; ifs.load = ld;
                     ifs.load_lsd = 4'(lsd); ifs.load_msd = 3'(msd); end
            3: begin ifm.up = up; ifm.load = ld;
                     ifm.load_lsd = 4'(lsd); ifm.load_msd = 3'(msd); end
            4: begin ifh.up = up; ifh.load = ld;
                     ifh.load_lsd = 4'(lsd); ifh.load_msd = 3'(msd); end
            5: begin if5.en = en; if5.up = up; if5.load = ld;
                     if5.load_lsd = 4'(lsd); if5.load_msd = 3'(msd); end
            6: begin if100.en = en; if100.up = up; if100.load = ld;
                     if100.load_lsd = 4'(lsd); if100.load_msd = 4'(msd); end
            7: begin if10.en = en; if10.up = up; if10.load = ld;
                     if10.load_lsd = 4'(lsd); if10.load_msd = 3'(msd); end
            default: ;
        endcase
    endtask

    task automatic chk(input int id, input int lsd, input int msd, input bit c,
                       input bit e, input string nm, input bit ph = 1'b0);
        exp_t x;
        x.id     = id;
        x.at_cyc = cyc;
        x.ph     = ph;
        x.val    = {e, c, 4'(msd), 4'(lsd)};
        x.name   = nm;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t       x;
        logic [9:0] act;
        bit         ph;
        forever begin
            @(negedge clk or posedge probe);
            ph = probe;
            while (q.size() > 0 &&
                   (q[0].at_cyc < cyc || (q[0].at_cyc == cyc && q[0].ph == ph))) begin
                x = q.pop_front();
                tests++;
                if (x.at_cyc < cyc) begin
                    fails++;
                    $display("FAIL %s: expectation not sampled in cycle %0d (now %0d)",
                             x.name, x.at_cyc, cyc);
                end else begin
                    act = obs(x.id);
                    if (act !== x.val) begin
                        fails++;
                        $display("FAIL %s: dut%0d got err=%b carry=%b msd=%0d lsd=%0d, want err=%b carry=%b msd=%0d lsd=%0d",
                                 x.name, x.id, act[9], act[8], act[7:4], act[3:0],
                                 x.val[9], x.val[8], x.val[7:4], x.val[3:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin : stim
        rst   = 1'b1;
        rst_x = 1'b0;
        for (int i = 0; i < 8; i++) set_in(i, 1'b0, 1'b1, 1'b0, 0, 0);
        step();
        for (int i = 0; i < 8; i++) chk(i, (i == 5) ? 5 : 0, 0, 1'b0, 1'b0, "reset");
        step();
        rst = 1'b0;

        // Full up-count over one period of the seconds field.
        set_in(0, 1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i <= 60; i++) begin
            chk(0, (i % 60) % 10, (i % 60) / 10, (i == 59), 1'b0, "t1_count");
            step();
        end
        set_in(0, 1'b0, 1'b1, 1'b0, 0, 0);

        // Load priority, illegal loads, direction changes at the wrap points.
        set_in(0, 1'b1, 1'b1, 1'b1, 5, 4);  chk(0, 1, 0, 0, 0, "t3_pre");          step();
        set_in(0, 1'b0, 1'b1, 1'b0, 0, 0);  chk(0, 5, 4, 0, 0, "t3_load_wins");    step();
        set_in(0, 1'b0, 1'b1, 1'b1, 7, 6);  chk(0, 5, 4, 0, 0, "t3_bad_cycle");    step();
        set_in(0, 1'b0, 1'b1, 1'b0, 0, 0);  chk(0, 5, 4, 0, 1, "t3_err_pulse");    step();
        chk(0, 5, 4, 0, 0, "t3_err_clear");                                        step();
        set_in(0, 1'b0, 1'b1, 1'b1, 10, 1); chk(0, 5, 4, 0, 0, "t3_bad_lsd");      step();
        set_in(0, 1'b0, 1'b1, 1'b1, 9, 5);  chk(0, 5, 4, 0, 1, "t3_err_lsd");      step();
        set_in(0, 1'b1, 1'b1, 1'b1, 0, 0);  chk(0, 9, 5, 0, 0, "t3_load_nocarry"); step();
        set_in(0, 1'b1, 1'b0, 1'b0, 0, 0);  chk(0, 0, 0, 1, 0, "t3_down_wrap");    step();
        set_in(0, 1'b1, 1'b1, 1'b0, 0, 0);  chk(0, 9, 5, 1, 0, "t3_up_wrap");      step();
        set_in(0, 1'b0, 1'b1, 1'b0, 0, 0);  chk(0, 0, 0, 0, 0, "t3_after_wrap");   step();

        // Hours counting down with single enable pulses.
        set_in(1, 1'b1, 1'b0, 1'b0, 0, 0); chk(1, 0, 0, 1, 0, "t2_borrow_00"); step();
        set_in(1, 1'b0, 1'b0, 1'b0, 0, 0); chk(1, 3, 2, 0, 0, "t2_23");        step();
        set_in(1, 1'b1, 1'b0, 1'b0, 0, 0); chk(1, 3, 2, 0, 0, "t2_pulse23");   step();
        set_in(1, 1'b0, 1'b0, 1'b0, 0, 0); chk(1, 2, 2, 0, 0, "t2_22");        step();
        set_in(1, 1'b1, 1'b0, 1'b0, 0, 0); chk(1, 2, 2, 0, 0, "t2_pulse22");   step();
        set_in(1, 1'b0, 1'b0, 1'b0, 0, 0); chk(1, 1, 2, 0, 0, "t2_21");        step();
        set_in(1, 1'b1, 1'b0, 1'b0, 0, 0); chk(1, 1, 2, 0, 0, "t2_pulse21");   step();
        set_in(1, 1'b1, 1'b0, 1'b0, 0, 0); chk(1, 0, 2, 0, 0, "t2_20");        step();
        set_in(1, 1'b0, 1'b0, 1'b0, 0, 0); chk(1, 9, 1, 0, 0, "t2_19");        step();

        // Cascade preloaded to 23:59:58.
        set_in(2, 1'b0, 1'b1, 1'b1, 8, 5);
        set_in(3, 1'b0, 1'b1, 1'b1, 9, 5);
        set_in(4, 1'b0, 1'b1, 1'b1, 3, 2);
        chk(2, 0, 0, 0, 0, "t4_sec_pre"); chk(3, 0, 0, 0, 0, "t4_min_pre");
        chk(4, 0, 0, 0, 0, "t4_hora_pre");
        step();
        set_in(2, 1'b1, 1'b1, 1'b0, 0, 0);
        set_in(3, 1'b0, 1'b1, 1'b0, 0, 0);
        set_in(4, 1'b0, 1'b1, 1'b0, 0, 0);
        chk(2, 8, 5, 0, 0, "t4_sec58"); chk(3, 9, 5, 0, 0, "t4_min59_idle");
        chk(4, 3, 2, 0, 0, "t4_hora23_idle");
        step();
        chk(2, 9, 5, 1, 0, "t4_sec59"); chk(3, 9, 5, 1, 0, "t4_min_carry");
        chk(4, 3, 2, 1, 0, "t4_hora_carry");
        step();
        set_in(2, 1'b0, 1'b1, 1'b0, 0, 0);
        chk(2, 0, 0, 0, 0, "t4_sec00"); chk(3, 0, 0, 0, 0, "t4_min00");
        chk(4, 0, 0, 0, 0, "t4_hora00");
        step();

        // Asynchronous reset pulse entirely between two clock edges.
        set_in(5, 1'b0, 1'b1, 1'b1, 7, 3); chk(5, 5, 0, 0, 0, "t5_pre");  step();
        set_in(5, 1'b1, 1'b1, 1'b0, 0, 0); chk(5, 7, 3, 0, 0, "t5_at37");
        @(negedge clk);
        #1 rst_x = 1'b1;
        #1 chk(5, 5, 0, 0, 0, "t5_async_rst", 1'b1);
        probe = 1'b1;
        #1 probe = 1'b0;
        rst_x = 1'b0;
        step();
        set_in(5, 1'b0, 1'b1, 1'b0, 0, 0); chk(5, 6, 0, 0, 0, "t5_resume06"); step();

        // MODULO=100: 99 <-> 00 wraps and a load of 100 is rejected.
        set_in(6, 1'b0, 1'b1, 1'b1, 9, 9);  chk(6, 0, 0, 0, 0, "t6_pre");       step();
        set_in(6, 1'b1, 1'b1, 1'b0, 0, 0);  chk(6, 9, 9, 1, 0, "t6_up99");      step();
        set_in(6, 1'b1, 1'b0, 1'b0, 0, 0);  chk(6, 0, 0, 1, 0, "t6_down00");    step();
        set_in(6, 1'b0, 1'b1, 1'b1, 0, 10); chk(6, 9, 9, 0, 0, "t6_bad100");    step();
        set_in(6, 1'b0, 1'b1, 1'b0, 0, 0);  chk(6, 9, 9, 0, 1, "t6_err100");    step();

        // MODULO=10: single-digit wrap both ways, tens digit pinned at 0.
        set_in(7, 1'b1, 1'b0, 1'b0, 0, 0); chk(7, 0, 0, 1, 0, "t6b_down0");    step();
        set_in(7, 1'b1, 1'b1, 1'b0, 0, 0); chk(7, 9, 0, 1, 0, "t6b_up9");      step();
        chk(7, 0, 0, 0, 0, "t6b_at0");                                         step();
        set_in(7, 1'b0, 1'b1, 1'b1, 0, 1); chk(7, 1, 0, 0, 0, "t6b_at1");      step();
        set_in(7, 1'b0, 1'b1, 1'b0, 0, 0); chk(7, 1, 0, 0, 1, "t6b_err10");    step();
        chk(7, 1, 0, 0, 0, "t6b_hold");                                        step();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
